// File: rtl/NanoCore_pkg.sv
// NanoCore_pkg: shared instruction-queue entry type and default queue depth.
package NanoCore_pkg;
   localparam int IQ_DEPTH_DEF = 8;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } iq_entry_t;
endpackage

// File: rtl/n2_iq_store.sv
// n2_iq_store: instruction-queue storage, two write ports and two asynchronous read ports.
module n2_iq_store
   import NanoCore_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH_DEF,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we0,
   input  logic [AW-1:0] wa0,
   input  iq_entry_t     wd0,
   input  logic          we1,
   input  logic [AW-1:0] wa1,
   input  iq_entry_t     wd1,
   input  logic [AW-1:0] ra0,
   input  logic [AW-1:0] ra1,
   output iq_entry_t     rd0,
   output iq_entry_t     rd1
);
   iq_entry_t mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end
   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];
endmodule

// File: rtl/n2_instr_resp.sv
// n2_instr_resp: fetch grant, single-beat response capture and instruction-queue pointer control.
module n2_instr_resp
   import NanoCore_pkg::*;
#(
   parameter int IQ_DEPTH = IQ_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic                       instr_req_i,
   input  logic [1:0]                 instr_req_2b_i,
   input  logic [31:0]                instr_addr_i,
   output logic                       instr_gnt_o,
   output logic                       mem_rden_o,
   output logic [28:0]                mem_addr_o,
   input  logic [63:0]                mem_rdata_i,
   output logic [1:0]                 iq_valid_o,
   output logic [31:0]                iq_instr0_o,
   output logic [31:0]                iq_instr1_o,
   output logic [31:0]                iq_pc0_o,
   output logic [31:0]                iq_pc1_o,
   input  logic [1:0]                 iq_pop_i,
   output logic [$clog2(IQ_DEPTH):0]  iq_usedw_o
);
   localparam int AW = $clog2(IQ_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW:0] LIMIT = (PW+1)'(IQ_DEPTH - 2);
   logic [PW-1:0] wr_ptr, rd_ptr, usedw;
   logic          resp_valid, resp_hi, push, v0, v1;
   logic [1:0]    resp_mask, inflight, push_n, pop_n, eff_mask;
   logic [31:0]   resp_pc;
   iq_entry_t     wd0, wd1, rd0, rd1;
   assign usedw = wr_ptr - rd_ptr;
   assign inflight = resp_valid ? (resp_mask[1] ? 2'd2 : 2'd1) : 2'd0;
   assign instr_gnt_o = instr_req_i & ~flush_i & ~reset &
                        ({1'b0, usedw} + (PW+1)'(inflight) <= LIMIT);
   assign mem_rden_o = instr_gnt_o;
   assign mem_addr_o = instr_addr_i[31:3];
   // An upper-half PC or a mask without bit0 still fetches exactly one word.
   assign eff_mask = (instr_addr_i[2] | ~instr_req_2b_i[0]) ? 2'b01 : instr_req_2b_i;
   assign push = resp_valid & ~flush_i & ~reset;
   assign push_n = push ? (resp_mask[1] ? 2'd2 : 2'd1) : 2'd0;
   assign wd0 = '{pc: resp_pc, instr: resp_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0]};
   assign wd1 = '{pc: resp_pc + 32'd4, instr: mem_rdata_i[63:32]};
   assign v0 = usedw != '0;
   assign v1 = usedw >= PW'(2);
   assign pop_n = (flush_i | ~iq_pop_i[0] | ~v0) ? 2'd0 : (iq_pop_i[1] & v1) ? 2'd2 : 2'd1;
   assign iq_valid_o = reset ? 2'b00 : {v1, v0};
   assign iq_usedw_o = reset ? '0 : usedw;
   assign iq_instr0_o = iq_valid_o[0] ? rd0.instr : '0;
   assign iq_pc0_o = iq_valid_o[0] ? rd0.pc : '0;
   assign iq_instr1_o = iq_valid_o[1] ? rd1.instr : '0;
   assign iq_pc1_o = iq_valid_o[1] ? rd1.pc : '0;
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         resp_valid <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_n);
         rd_ptr <= rd_ptr + PW'(pop_n);
         resp_valid <= instr_gnt_o;
      end
   end
   always_ff @(posedge clk) begin
      if (instr_gnt_o) begin
         resp_mask <= eff_mask;
         resp_pc <= instr_addr_i;
         resp_hi <= instr_addr_i[2];
      end
   end
   n2_iq_store #(.DEPTH(IQ_DEPTH)) u_store (
      .clk(clk),
      .we0(push),
      .wa0(wr_ptr[AW-1:0]),
      .wd0(wd0),
      .we1(push & resp_mask[1]),
      .wa1(wr_ptr[AW-1:0] + AW'(1)),
      .wd1(wd1),
      .ra0(rd_ptr[AW-1:0]),
      .ra1(rd_ptr[AW-1:0] + AW'(1)),
      .rd0(rd0),
      .rd1(rd1)
   );
endmodule

// File: tb/tb_n2_instr_resp.sv
// tb_n2_instr_resp: vector table plus scoreboarded corner sequences for n2_instr_resp.
module tb_n2_instr_resp;
   logic clk = 0, reset = 1, flush = 0, req = 0;
   logic [1:0] req_2b = 0, pop = 0, valid;
   logic [31:0] addr = 0, i0, i1, p0, p1;
   logic [63:0] rdata = 0;
   logic gnt, rden;
   logic [28:0] maddr;
   logic [3:0] usedw;
   int tests = 0, failed = 0;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t sbq[$];
   typedef struct {
      logic [31:0] a; logic [1:0] m; logic [63:0] d;
      logic [1:0] ev; logic [3:0] eu;
      logic [31:0] ei0, ep0, ei1, ep1;
   } vec_t;
   vec_t vt[6];
   n2_instr_resp #(.IQ_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .flush_i(flush), .instr_req_i(req),
      .instr_req_2b_i(req_2b), .instr_addr_i(addr), .instr_gnt_o(gnt),
      .mem_rden_o(rden), .mem_addr_o(maddr), .mem_rdata_i(rdata),
      .iq_valid_o(valid), .iq_instr0_o(i0), .iq_instr1_o(i1),
      .iq_pc0_o(p0), .iq_pc1_o(p1), .iq_pop_i(pop), .iq_usedw_o(usedw)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end
   function automatic logic [31:0] w(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction
   task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h required %h", n, act, exp);
      end
   endtask
   task automatic push_exp(input logic [31:0] a, input logic [1:0] m, input logic [63:0] d);
      if (a[2]) sbq.push_back('{a, d[63:32]});
      else begin
         sbq.push_back('{a, d[31:0]});
         if (m == 2'b11) sbq.push_back('{a + 32'd4, d[63:32]});
      end
   endtask
   task automatic pop_sb(input logic [1:0] p);
      int n = p[0] ? (p[1] ? 2 : 1) : 0;
      if (n > sbq.size()) n = sbq.size();
      repeat (n) void'(sbq.pop_front());
   endtask
   task automatic check_head();
      int sz = sbq.size();
      check("valid", valid, {sz >= 2, sz >= 1});
      check("usedw", usedw, sz);
      check("instr0", i0, sz >= 1 ? sbq[0].instr : 32'd0);
      check("pc0", p0, sz >= 1 ? sbq[0].pc : 32'd0);
      check("instr1", i1, sz >= 2 ? sbq[1].instr : 32'd0);
      check("pc1", p1, sz >= 2 ? sbq[1].pc : 32'd0);
   endtask
   // Starts at a negedge; returns at the negedge where the fetched words are visible.
   task automatic fetch(input logic [31:0] a, input logic [1:0] m, input logic [63:0] d, input logic eg);
      req = 1; req_2b = m; addr = a;
      #1;
      check("gnt", gnt, eg);
      check("rden", rden, eg);
      check("mem_addr", maddr, a[31:3]);
      if (gnt) push_exp(a, m, d);
      @(negedge clk);
      req = 0; rdata = d;
      #1;
      check("no_bypass", valid, {sbq.size() - (eg ? (m == 2'b11 && !a[2] ? 2 : 1) : 0) >= 2,
                                 sbq.size() - (eg ? (m == 2'b11 && !a[2] ? 2 : 1) : 0) >= 1});
      @(negedge clk);
   endtask
   task automatic do_pop(input logic [1:0] p);
      pop = p;
      @(negedge clk);
      pop = 0;
      pop_sb(p);
   endtask
   initial begin
      logic [31:0] a, pa;
      int grants;
      vt[0] = '{32'h100, 2'b11, 64'h22222222_11111111, 2'b11, 4'd2, 32'h11111111, 32'h100, 32'h22222222, 32'h104};
      vt[1] = '{32'h104, 2'b11, 64'hAAAAAAAA_BBBBBBBB, 2'b01, 4'd1, 32'hAAAAAAAA, 32'h104, 32'h0, 32'h0};
      vt[2] = '{32'h200, 2'b00, 64'h33333333_44444444, 2'b01, 4'd1, 32'h44444444, 32'h200, 32'h0, 32'h0};
      vt[3] = '{32'h208, 2'b10, 64'h55555555_66666666, 2'b01, 4'd1, 32'h66666666, 32'h208, 32'h0, 32'h0};
      vt[4] = '{32'h30C, 2'b01, 64'h77777777_88888888, 2'b01, 4'd1, 32'h77777777, 32'h30C, 32'h0, 32'h0};
      vt[5] = '{32'hFFFFFFF8, 2'b11, 64'h99999999_CCCCCCCC, 2'b11, 4'd2, 32'hCCCCCCCC, 32'hFFFFFFF8, 32'h99999999, 32'hFFFFFFFC};
      // Reset state with a request pending.
      req = 1; req_2b = 2'b11; addr = 32'h40;
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_rden", rden, 0);
      check("rst_valid", valid, 0);
      check("rst_usedw", usedw, 0);
      check("rst_instr0", i0, 0);
      reset = 0; req = 0;
      @(negedge clk);
      check_head();
      foreach (vt[k]) begin
         fetch(vt[k].a, vt[k].m, vt[k].d, 1);
         check($sformatf("vec%0d_valid", k), valid, vt[k].ev);
         check($sformatf("vec%0d_usedw", k), usedw, vt[k].eu);
         check($sformatf("vec%0d_instr0", k), i0, vt[k].ei0);
         check($sformatf("vec%0d_pc0", k), p0, vt[k].ep0);
         check($sformatf("vec%0d_instr1", k), i1, vt[k].ei1);
         check($sformatf("vec%0d_pc1", k), p1, vt[k].ep1);
         check_head();
         do_pop(2'b11);
         check_head();
      end
      // Back-pressure: continuous mask-11 requests fill the queue.
      a = 32'h1000; pa = 32'h0; grants = 0;
      for (int c = 0; c < 8; c++) begin
         req = 1; req_2b = 2'b11; addr = a; rdata = {w(pa + 32'd4), w(pa)};
         #1;
         if (gnt) begin
            grants++;
            push_exp(a, 2'b11, {w(a + 32'd4), w(a)});
            pa = a; a += 32'd8;
         end
         @(negedge clk);
      end
      check("grants", grants, 4);
      check("full_usedw", usedw, 8);
      pop = 2'b11;
      #1;
      check("full_gnt", gnt, 0);
      check_head();
      @(negedge clk);
      pop = 0; pop_sb(2'b11);
      #1;
      check("gnt_after_pop", gnt, 1);
      req = 0;
      check_head();
      do_pop(2'b01);
      check_head();
      // Flush the cycle after a grant at usedw=5.
      req = 1; req_2b = 2'b11; addr = 32'h2000;
      #1;
      check("pre_flush_gnt", gnt, 1);
      @(negedge clk);
      flush = 1; rdata = 64'hBAD0BAD1_BAD2BAD3; pop = 2'b11;
      #1;
      check("flush_gnt", gnt, 0);
      @(negedge clk);
      flush = 0; req = 0; pop = 0;
      sbq.delete();
      check_head();
      fetch(32'h3000, 2'b11, {w(32'h3004), w(32'h3000)}, 1);
      check_head();
      fetch(32'h3008, 2'b11, {w(32'h300C), w(32'h3008)}, 1);
      fetch(32'h3010, 2'b11, {w(32'h3014), w(32'h3010)}, 1);
      fetch(32'h3018, 2'b01, {w(32'h301C), w(32'h3018)}, 1);
      check_head();
      do_pop(2'b01);
      check_head();
      // Write index 7: two-word push and single pop in the same cycle wrap the index.
      req = 1; req_2b = 2'b11; addr = 32'h3020;
      #1;
      check("wrap_gnt", gnt, 1);
      push_exp(32'h3020, 2'b11, {w(32'h3024), w(32'h3020)});
      @(negedge clk);
      req = 0; rdata = {w(32'h3024), w(32'h3020)}; pop = 2'b01;
      @(negedge clk);
      pop = 0; pop_sb(2'b01);
      check("wrap_usedw", usedw, 7);
      check_head();
      for (int g = 0; g < 8 && sbq.size() > 0; g++) begin
         do_pop(2'b11);
         check_head();
      end
      // Over-pop with one entry, then reset mid-fetch.
      fetch(32'h4004, 2'b11, {w(32'h4004), 32'h0}, 1);
      check_head();
      do_pop(2'b11);
      check_head();
      fetch(32'h4010, 2'b11, {w(32'h4014), w(32'h4010)}, 1);
      check_head();
      req = 1; req_2b = 2'b11; addr = 32'h5000;
      #1;
      check("pre_rst_gnt", gnt, 1);
      @(negedge clk);
      reset = 1; rdata = 64'h5555AAAA_AAAA5555;
      #1;
      check("midrst_gnt", gnt, 0);
      check("midrst_rden", rden, 0);
      check("midrst_valid", valid, 0);
      check("midrst_usedw", usedw, 0);
      check("midrst_instr0", i0, 0);
      check("midrst_pc0", p0, 0);
      @(negedge clk);
      reset = 0; req = 0;
      sbq.delete();
      check_head();
      @(negedge clk);
      check_head();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
